// File: rtl/mem_bridge.sv
// Memory-side bridge: one outstanding core request, decoded to synchronous RAM, machine-timer MMIO or fault.
// Define MEM_BRIDGE_TIMER_EN to build mtime/mtimecmp; without it the timer range faults and timer_irq is 0.
//
// state      | meaning
// IDLE       | req_ready high, waiting for req_enable
// ERROR_RESP | fault response pulse, no side effects
// RAM_ISSUE  | ram_en pulse with address/strobes/data
// RAM_WAIT   | down-count read latency, capture ram_rdata at terminal count
// MMIO       | one-cycle timer register access
// RESP       | normal response pulse
module mem_bridge #(
    parameter int          RAM_ADDR_WIDTH = 14,
    parameter logic [31:0] RAM_BASE       = 32'h0000_0000,
    parameter logic [31:0] MMIO_BASE      = 32'h8000_0000,
    parameter int          RAM_LATENCY    = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      req_ready,
    input  logic                      req_enable,
    input  logic                      req_write,
    input  logic [31:0]               req_addr,
    input  logic [1:0]                req_size,
    input  logic [31:0]               req_wdata,
    input  logic [3:0]                req_wstrb,
    output logic                      resp_valid,
    output logic [31:0]               resp_rdata,
    output logic                      resp_error,
    output logic                      ram_en,
    output logic [3:0]                ram_we,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]               ram_wdata,
    input  logic [31:0]               ram_rdata,
    output logic                      timer_irq
);

    localparam int CNT_W = $clog2(RAM_LATENCY + 1);

`ifdef MEM_BRIDGE_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        ERROR_RESP,
        RAM_ISSUE,
        RAM_WAIT,
        MMIO,
        RESP
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic               ram_hit;
    logic               mmio_hit;
    logic               misaligned;
    logic               fault;
    logic [31:0]        mmio_rdata;

    always_comb begin
        ram_hit    = (req_addr[31:RAM_ADDR_WIDTH+2] == RAM_BASE[31:RAM_ADDR_WIDTH+2]);
        mmio_hit   = TIMER_EN && (req_addr[31:4] == MMIO_BASE[31:4]);
        misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                     ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
        fault      = misaligned || (req_size == 2'd3) || !(ram_hit || mmio_hit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= '0;
            ram_en     <= 1'b0;
            ram_we     <= '0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_enable) begin
                        req_ready <= 1'b0;
                        ram_addr  <= req_addr[RAM_ADDR_WIDTH+1:2];
                        // ram_wdata doubles as the latched write data for MMIO writes
                        ram_wdata <= req_wdata;
                        if (fault) begin
                            state      <= ERROR_RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= '0;
                        end else if (ram_hit) begin
                            state  <= RAM_ISSUE;
                            ram_en <= 1'b1;
                            ram_we <= req_write ? req_wstrb : 4'b0000;
                        end else begin
                            state <= MMIO;
                        end
                    end
                end
                ERROR_RESP: begin
                    resp_valid <= 1'b0;
                    resp_error <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                RAM_ISSUE: begin
                    ram_en   <= 1'b0;
                    ram_we   <= '0;
                    wait_cnt <= CNT_W'(RAM_LATENCY);
                    state    <= RAM_WAIT;
                end
                RAM_WAIT: begin
                    wait_cnt <= wait_cnt - CNT_W'(1);
                    if (wait_cnt == CNT_W'(1)) begin
                        resp_rdata <= ram_rdata;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b0;
                        state      <= RESP;
                    end
                end
                MMIO: begin
                    resp_rdata <= mmio_rdata;
                    resp_valid <= 1'b1;
                    resp_error <= 1'b0;
                    state      <= RESP;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_BRIDGE_TIMER_EN
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [1:0]  mmio_off;
    logic [3:0]  mmio_wstrb;
    logic        mmio_write;
    logic        mmio_wr;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] result;
        for (int b = 0; b < 4; b++) begin
            result[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return result;
    endfunction

    assign mmio_wr = (state == MMIO) && mmio_write;

    always_comb begin
        case (mmio_off)
            2'd0:    mmio_rdata = mtime[31:0];
            2'd1:    mmio_rdata = mtime[63:32];
            2'd2:    mmio_rdata = mtimecmp[31:0];
            default: mmio_rdata = mtimecmp[63:32];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mtime      <= '0;
            mtimecmp   <= '1;
            timer_irq  <= 1'b0;
            mmio_off   <= '0;
            mmio_wstrb <= '0;
            mmio_write <= 1'b0;
        end else begin
            timer_irq <= (mtime >= mtimecmp);
            if ((state == IDLE) && req_enable) begin
                mmio_off   <= req_addr[3:2];
                mmio_wstrb <= req_wstrb;
                mmio_write <= req_write;
            end
            // a software write to mtime takes the place of that cycle's increment
            if (mmio_wr && (mmio_off == 2'd0))
                mtime[31:0] <= merge_lanes(mtime[31:0], ram_wdata, mmio_wstrb);
            else if (mmio_wr && (mmio_off == 2'd1))
                mtime[63:32] <= merge_lanes(mtime[63:32], ram_wdata, mmio_wstrb);
            else
                mtime <= mtime + 64'd1;
            if (mmio_wr && (mmio_off == 2'd2))
                mtimecmp[31:0] <= merge_lanes(mtimecmp[31:0], ram_wdata, mmio_wstrb);
            if (mmio_wr && (mmio_off == 2'd3))
                mtimecmp[63:32] <= merge_lanes(mtimecmp[63:32], ram_wdata, mmio_wstrb);
        end
    end
`else
    assign mmio_rdata = '0;
    assign timer_irq  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: behavioural RAM with latency, scoreboard of expected responses.
`timescale 1ns/1ps
module tb_mem_bridge;
    localparam int          AW    = 10;
    localparam int          LAT   = 2;
    localparam int          WORDS = 1 << AW;
    localparam logic [31:0] MB    = 32'h8000_0000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_ready;
    logic          req_enable = 1'b0;
    logic          req_write = 1'b0;
    logic [31:0]   req_addr = '0;
    logic [1:0]    req_size = '0;
    logic [31:0]   req_wdata = '0;
    logic [3:0]    req_wstrb = '0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_error;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
    logic          timer_irq;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          chk;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  size;
    } fault_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_pass = 0;
    int          n_total = 0;
    int          resp_pulses = 0;
    int          ram_en_cnt = 0;
    int          cyc = 0;
    logic [31:0] mem     [0:WORDS-1];
    logic [31:0] ref_mem [0:WORDS-1];
    logic [31:0] rd_pipe [0:LAT-1];
    bit          mem_loaded = 1'b0;

    always #5 clk = ~clk;

    mem_bridge #(
        .RAM_ADDR_WIDTH(AW),
        .RAM_BASE(32'h0000_0000),
        .MMIO_BASE(MB),
        .RAM_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_ready(req_ready), .req_enable(req_enable), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .timer_irq(timer_irq)
    );

    function automatic logic [31:0] pat(input int i);
        if (i == 3) return 32'hDEAD_BEEF;
        return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0101);
    endfunction

    // RAM model: read-before-write, data appears LAT cycles after the ram_en cycle
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mem_loaded) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= pat(i);
            mem_loaded <= 1'b1;
        end else if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
        rd_pipe[0] <= ram_en ? mem[ram_addr] : 32'h0BAD_F00D;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rdata = rd_pipe[LAT-1];

    always @(negedge clk) begin
        if (ram_en === 1'b1) ram_en_cnt++;
        if (resp_valid === 1'b1) begin
            resp_pulses++;
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL resp_unexpected got err=%b rdata=%h want no response", resp_error, resp_rdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (resp_error !== mon_e.err || (mon_e.chk && resp_rdata !== mon_e.rdata))
                    $display("FAIL resp_data got err=%b rdata=%h want err=%b rdata=%h",
                             resp_error, resp_rdata, mon_e.err, mon_e.rdata);
                else n_pass++;
            end
            n_total++;
            if (req_ready !== 1'b0) $display("FAIL resp_ready_low got %b want 0", req_ready);
            else n_pass++;
        end
    end

    task automatic send(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        input bit push, input logic [31:0] erd, input logic eerr, input bit echk);
        int guard = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
        if (req_ready !== 1'b1) begin
            n_total++;
            $display("FAIL send_timeout got req_ready=%b want 1", req_ready);
        end
        if (push) exp_q.push_back('{erd, eerr, echk});
        req_write = wr; req_addr = addr; req_size = size; req_wdata = wdata; req_wstrb = wstrb;
        req_enable = 1'b1;
        @(negedge clk);
        req_enable = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() != 0 || req_ready !== 1'b1) && guard < 100) begin
            @(negedge clk); guard++;
        end
        if (guard >= 100) begin
            n_total++;
            $display("FAIL drain_timeout got pending=%0d want 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready got %b want 1", req_ready); else n_pass++;
        n_total++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %b want 0", resp_valid); else n_pass++;
        n_total++; if (resp_error !== 1'b0) $display("FAIL rst_resp_error got %b want 0", resp_error); else n_pass++;
        n_total++; if (resp_rdata !== 32'h0) $display("FAIL rst_resp_rdata got %h want 0", resp_rdata); else n_pass++;
        n_total++; if (ram_en !== 1'b0) $display("FAIL rst_ram_en got %b want 0", ram_en); else n_pass++;
        n_total++; if (ram_we !== 4'h0) $display("FAIL rst_ram_we got %b want 0", ram_we); else n_pass++;
        n_total++; if (timer_irq !== 1'b0) $display("FAIL rst_timer_irq got %b want 0", timer_irq); else n_pass++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word_read();
        int en0 = ram_en_cnt;
        send(1'b0, 32'hC, 2'd2, 32'h0, 4'h0, 1'b1, ref_mem[3], 1'b0, 1'b1);
        n_total++; if (ram_en !== 1'b1) $display("FAIL rd_ram_en got %b want 1", ram_en); else n_pass++;
        n_total++; if (ram_addr !== AW'(3)) $display("FAIL rd_ram_addr got %0d want 3", ram_addr); else n_pass++;
        n_total++; if (ram_we !== 4'h0) $display("FAIL rd_ram_we got %b want 0", ram_we); else n_pass++;
        for (int c = 2; c <= LAT + 2; c++) begin
            @(negedge clk);
            if (c == 2) begin
                n_total++; if (ram_en !== 1'b0) $display("FAIL rd_ram_en_pulse got %b want 0", ram_en); else n_pass++;
            end
            if (c == LAT + 1) begin
                n_total++; if (resp_valid !== 1'b0) $display("FAIL rd_early_resp got %b want 0", resp_valid); else n_pass++;
            end
            if (c == LAT + 2) begin
                n_total++; if (resp_valid !== 1'b1) $display("FAIL rd_resp_cycle got %b want 1", resp_valid); else n_pass++;
            end
        end
        drain();
        n_total++;
        if (ram_en_cnt - en0 != 1) $display("FAIL rd_ram_en_count got %0d want 1", ram_en_cnt - en0);
        else n_pass++;
    endtask

    task automatic test_byte_write();
        send(1'b1, 32'h5, 2'd0, 32'h0000_AB00, 4'b0010, 1'b1, 32'h0, 1'b0, 1'b0);
        n_total++; if (ram_we !== 4'b0010) $display("FAIL bw_ram_we got %b want 0010", ram_we); else n_pass++;
        n_total++; if (ram_addr !== AW'(1)) $display("FAIL bw_ram_addr got %0d want 1", ram_addr); else n_pass++;
        n_total++; if (ram_wdata !== 32'h0000_AB00) $display("FAIL bw_ram_wdata got %h want 0000ab00", ram_wdata); else n_pass++;
        ref_mem[1][15:8] = 8'hAB;
        drain();
        send(1'b0, 32'h4, 2'd2, 32'h0, 4'h0, 1'b1, ref_mem[1], 1'b0, 1'b1);
        drain();
        send(1'b1, 32'hA, 2'd1, 32'h1234_0000, 4'b1100, 1'b1, 32'h0, 1'b0, 1'b0);
        ref_mem[2][31:16] = 16'h1234;
        drain();
        send(1'b0, 32'h8, 2'd2, 32'h0, 4'h0, 1'b1, ref_mem[2], 1'b0, 1'b1);
        drain();
        send(1'b1, 32'hFFC, 2'd2, 32'hCAFE_F00D, 4'hF, 1'b1, 32'h0, 1'b0, 1'b0);
        ref_mem[WORDS-1] = 32'hCAFE_F00D;
        drain();
        send(1'b0, 32'hFFF, 2'd0, 32'h0, 4'h0, 1'b1, ref_mem[WORDS-1], 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_faults();
        fault_t fl [5];
        int bad = 0;
        fl[0] = '{1'b0, 32'h0000_0002, 2'd2};
        fl[1] = '{1'b1, 32'h4000_0000, 2'd2};
        fl[2] = '{1'b0, 32'h0000_0008, 2'd3};
        fl[3] = '{1'b1, 32'h0000_0001, 2'd1};
        fl[4] = '{1'b1, 32'h0000_1000, 2'd2};
        for (int k = 0; k < 5; k++) begin
            int en0 = ram_en_cnt;
            send(fl[k].wr, fl[k].addr, fl[k].size, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0, 1'b1, 1'b1);
            n_total++;
            if (resp_valid !== 1'b1 || resp_error !== 1'b1)
                $display("FAIL fault_cycle1_%0d got valid=%b err=%b want 1 1", k, resp_valid, resp_error);
            else n_pass++;
            drain();
            n_total++;
            if (ram_en_cnt != en0) $display("FAIL fault_no_ram_en_%0d got %0d want 0", k, ram_en_cnt - en0);
            else n_pass++;
        end
        for (int i = 0; i < WORDS; i++) if (mem[i] !== ref_mem[i]) bad++;
        n_total++;
        if (bad != 0) $display("FAIL fault_ram_intact got %0d changed words want 0", bad);
        else n_pass++;
    endtask

`ifdef MEM_BRIDGE_TIMER_EN
    task automatic test_timer();
        int t_w;
        int g = 0;
        send(1'b1, MB + 32'h4, 2'd2, 32'h0, 4'hF, 1'b1, 32'h0, 1'b0, 1'b0);
        send(1'b1, MB + 32'h0, 2'd2, 32'h0, 4'hF, 1'b1, 32'h0, 1'b0, 1'b0);
        t_w = cyc;
        send(1'b1, MB + 32'hC, 2'd2, 32'h0, 4'hF, 1'b1, 32'h0, 1'b0, 1'b0);
        send(1'b1, MB + 32'h8, 2'd2, 32'd50, 4'hF, 1'b1, 32'h0, 1'b0, 1'b0);
        while (cyc < t_w + 51 && g < 200) begin @(negedge clk); g++; end
        n_total++; if (timer_irq !== 1'b0) $display("FAIL irq_before got %b want 0", timer_irq); else n_pass++;
        @(negedge clk);
        n_total++; if (timer_irq !== 1'b1) $display("FAIL irq_rise got %b want 1", timer_irq); else n_pass++;
        send(1'b1, MB + 32'hC, 2'd2, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        n_total++; if (timer_irq !== 1'b1) $display("FAIL irq_hold got %b want 1", timer_irq); else n_pass++;
        @(negedge clk);
        n_total++; if (timer_irq !== 1'b0) $display("FAIL irq_fall got %b want 0", timer_irq); else n_pass++;
        send(1'b1, MB + 32'h8, 2'd2, 32'h1122_3344, 4'hF, 1'b1, 32'h0, 1'b0, 1'b0);
        send(1'b1, MB + 32'h8, 2'd2, 32'h00AA_0000, 4'b0100, 1'b1, 32'h0, 1'b0, 1'b0);
        send(1'b0, MB + 32'h8, 2'd2, 32'h0, 4'h0, 1'b1, 32'h11AA_3344, 1'b0, 1'b1);
        send(1'b0, MB + 32'hC, 2'd2, 32'h0, 4'h0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        drain();
        // back-to-back write then read: write cycle holds, then two increments
        send(1'b1, MB + 32'h0, 2'd2, 32'd1000, 4'hF, 1'b1, 32'h0, 1'b0, 1'b0);
        send(1'b0, MB + 32'h0, 2'd2, 32'h0, 4'h0, 1'b1, 32'd1002, 1'b0, 1'b1);
        drain();
        send(1'b1, MB + 32'h4, 2'd2, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0, 1'b0, 1'b0);
        send(1'b1, MB + 32'h0, 2'd2, 32'hFFFF_FFFE, 4'hF, 1'b1, 32'h0, 1'b0, 1'b0);
        send(1'b0, MB + 32'h0, 2'd2, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0, 1'b1);
        send(1'b0, MB + 32'h4, 2'd2, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0, 1'b1);
        drain();
    endtask
`else
    task automatic test_timer_absent();
        send(1'b0, MB, 2'd2, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1, 1'b1);
        send(1'b1, MB + 32'h8, 2'd2, 32'h0, 4'hF, 1'b1, 32'h0, 1'b1, 1'b1);
        drain();
        n_total++; if (timer_irq !== 1'b0) $display("FAIL no_timer_irq got %b want 0", timer_irq); else n_pass++;
    endtask
`endif

    task automatic test_back_to_back();
        int acc = 0;
        int p0 = resp_pulses;
        int e0 = ram_en_cnt;
        int guard = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
        req_write = 1'b0; req_size = 2'd2; req_wstrb = 4'h0;
        req_enable = 1'b1;
        for (int c = 0; c < 200 && acc < 3; c++) begin
            if (req_ready === 1'b1) begin
                req_addr = 32'h40 + 32'(acc * 4);
                exp_q.push_back('{ref_mem[16 + acc], 1'b0, 1'b1});
                acc++;
            end
            @(negedge clk);
        end
        req_enable = 1'b0;
        drain();
        n_total++; if (resp_pulses - p0 != 3) $display("FAIL b2b_pulses got %0d want 3", resp_pulses - p0); else n_pass++;
        n_total++; if (ram_en_cnt - e0 != 3) $display("FAIL b2b_ram_en got %0d want 3", ram_en_cnt - e0); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int p0 = resp_pulses;
        send(1'b0, 32'h10, 2'd2, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_total++; if (req_ready !== 1'b1) $display("FAIL rstmid_ready got %b want 1", req_ready); else n_pass++;
        n_total++; if (resp_valid !== 1'b0) $display("FAIL rstmid_valid got %b want 0", resp_valid); else n_pass++;
        repeat (LAT + 4) @(negedge clk);
        n_total++; if (resp_pulses != p0) $display("FAIL rstmid_no_resp got %0d want 0", resp_pulses - p0); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) ref_mem[i] = pat(i);
        test_reset();
        test_word_read();
        test_byte_write();
        test_faults();
`ifdef MEM_BRIDGE_TIMER_EN
        test_timer();
`else
        test_timer_absent();
`endif
        test_back_to_back();
        test_reset_mid();
        drain();
        n_total++;
        if (exp_q.size() != 0) $display("FAIL sb_empty got %0d want 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
Memory-side stage directly downstream of the multicycle core controller. Accepts the core's single outstanding fetch, load or store request over a ready/enable, valid handshake. Decodes the address to one of three targets: on-chip synchronous RAM with fixed read latency, a machine-timer MMIO block (mtime/mtimecmp, timer_irq), or an access fault. Returns one response pulse per accepted request.

Parameters:
RAM_ADDR_WIDTH, 14, RAM word-address width (RAM size = 4 * 2^RAM_ADDR_WIDTH bytes)
RAM_BASE, 32'h0000_0000, RAM byte base address, aligned to RAM size
MMIO_BASE, 32'h8000_0000, timer register block base, 16-byte region
RAM_LATENCY, 1, cycles from ram_en to valid ram_rdata, >= 1

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
req_ready  out  1  bridge idle, can accept a request
req_enable  in  1  request strobe, sampled only when req_ready=1
req_write  in  1  0 = read, 1 = write
req_addr  in  32  byte address
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
req_wdata  in  32  write data, lane-aligned by the core
req_wstrb  in  4  byte-lane write enables
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  full read word, valid with resp_valid
resp_error  out  1  access fault, valid with resp_valid
ram_en  out  1  RAM access strobe
ram_we  out  4  RAM byte write enables
ram_addr  out  RAM_ADDR_WIDTH  RAM word address
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data
timer_irq  out  1  level, mtime >= mtimecmp

Behaviour:
- Reset values:
  - req_ready=1; resp_valid=0; resp_error=0; resp_rdata=0.
  - ram_en=0; ram_we=0.
  - mtime=0; mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, so timer_irq=0.
  - FSM in IDLE.
- FSM states: IDLE, ERROR_RESP, RAM_ISSUE, RAM_WAIT, MMIO, RESP.
- IDLE: req_ready=1. On req_enable=1, latch write, addr, size, wdata and wstrb, drop req_ready, then decode:
  - Misaligned (half with addr[0]=1; word with addr[1:0]!=0), size=3, or address outside both regions -> ERROR_RESP.
  - RAM hit -> RAM_ISSUE.
  - MMIO hit (addr[31:4]==MMIO_BASE[31:4]) -> MMIO.
- ERROR_RESP: resp_valid=1, resp_error=1, resp_rdata=0. No ram_en, no MMIO side effect. Next state IDLE. Accept in cycle 0 gives response in cycle 1.
- RAM_ISSUE: ram_en=1 for exactly one cycle.
  - ram_addr = latched addr[RAM_ADDR_WIDTH+1:2].
  - ram_we = write ? wstrb : 0.
  - ram_wdata = latched wdata.
  - Next state RAM_WAIT, with the wait counter loaded to RAM_LATENCY.
- RAM_WAIT: decrement the counter each cycle. When it reaches 0, capture ram_rdata into resp_rdata (writes capture too; the value is don't-care) and go to RESP. With accept at cycle 0, resp_valid is asserted in cycle RAM_LATENCY+2.
- MMIO: one-cycle register access at offset addr[3:2].
  - Offset 0 = mtime[31:0]; 1 = mtime[63:32]; 2 = mtimecmp[31:0]; 3 = mtimecmp[63:32].
  - Writes honour wstrb per byte lane. Reads return the full word.
  - Next state RESP. Accept at cycle 0 gives resp_valid in cycle 2.
- RESP: resp_valid=1, resp_error=0, for one cycle. Next state IDLE; req_ready=1 in the following cycle.
- Only one request is outstanding at a time. req_enable outside IDLE is ignored.
- resp_rdata holds its value until the next capture.
- mtime:
  - Increments by 1 every cycle and wraps 2^64-1 -> 0.
  - A write to either mtime half in MMIO replaces the written bytes and suppresses the increment in that cycle.
  - An mtime read returns the pre-increment value of that cycle.
- timer_irq is registered: it reflects the comparison from the previous cycle. The compare is unsigned 64-bit.
- Writing mtimecmp halves one at a time may cause a transient timer_irq. This is accepted; software writes the high half to all-ones first.
- Reset mid-transaction aborts the access and returns to reset values. A ram_en already issued is not retracted.

Optional Feature:
MEM_BRIDGE_TIMER_EN
- Defined: MMIO region and timer behave as described above.
- Undefined: no mtime/mtimecmp registers are built, the MMIO address range decodes as unmapped (ERROR_RESP), and timer_irq is tied to 0.

Test Plan:
- Word read: RAM word 3 preloaded 32'hDEADBEEF, read addr 0xC size 2 -> ram_en one cycle with ram_addr=3; resp_valid at cycle RAM_LATENCY+2; resp_rdata=32'hDEADBEEF, resp_error=0.
- Byte write: write addr 0x5, size 0, wstrb 4'b0010, wdata 32'h0000AB00 -> ram_we=4'b0010, ram_addr=1; readback of word 1 shows byte 1 = 8'hAB and other bytes unchanged.
- Faults: read addr 0x2 size 2, write addr 0x4000_0000, and read with size 3 -> each gives resp_valid at cycle 1 with resp_error=1; no ram_en; RAM contents unchanged.
- Timer: write mtimecmp high = 0, then mtimecmp low = 50 -> timer_irq rises in the cycle after mtime reaches 50. Write mtimecmp high = 32'hFFFFFFFF -> timer_irq falls.
- Wrap: write mtime low = 32'hFFFFFFFE and mtime high = 32'hFFFFFFFF -> two cycles later mtime=0. A write cycle shows no increment.
- Handshake: hold req_enable=1 continuously for 3 back-to-back reads -> exactly 3 resp_valid pulses; req_ready low from accept through the response cycle. Reset asserted during RAM_WAIT -> no resp_valid; req_ready=1 one cycle after reset deasserts.
